// File: rtl/ram_bist.sv
// Built-in self-test initiator for a single-port synchronous RAM: write a pattern, read back, compare, report.
// Optional second inverted-pattern pass is enabled by defining BIST_INVERT_PASS_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for start, RAM strobes low, results zero
// WRITE       | writing (2k) mod 2^DATA_W to location k, one per cycle
// READ        | issuing one read per cycle, comparing the previous read
// DRAIN       | strobes low, last pending compare completes
// WRITE_INV   | writing the inverted pattern (BIST_INVERT_PASS_EN only)
// READ_INV    | reading back the inverted pattern (BIST_INVERT_PASS_EN only)
// DRAIN_INV   | last inverted compare completes (BIST_INVERT_PASS_EN only)
// DONE        | results held, pass valid, start begins a new run
module ram_bist #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_DRAIN     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
`ifdef BIST_INVERT_PASS_EN
    localparam logic [2:0] S_WRITE_INV = 3'd5;
    localparam logic [2:0] S_READ_INV  = 3'd6;
    localparam logic [2:0] S_DRAIN_INV = 3'd7;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_inv_q, pend_inv_d;
    logic [ADDR_W+1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

    logic              addr_last;
    logic              wr_phase;
    logic              rd_phase;
    logic              wr_inv;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'({a, 1'b0});
        return inv ? ~p : p;
    endfunction

    assign addr_last = &addr_q;
    assign mismatch  = pend_vld_q && (ram_rdata != pattern(pend_addr_q, pend_inv_q));

    always_comb begin
        wr_phase = 1'b0;
        rd_phase = 1'b0;
        wr_inv   = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_WRITE: begin
                wr_phase = 1'b1;
                busy     = 1'b1;
            end
            S_READ: begin
                rd_phase = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
`ifdef BIST_INVERT_PASS_EN
            S_WRITE_INV: begin
                wr_phase = 1'b1;
                wr_inv   = 1'b1;
                busy     = 1'b1;
            end
            S_READ_INV: begin
                rd_phase = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN_INV: busy = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        pend_vld_d  = 1'b0;
        pend_addr_d = addr_q;
        pend_inv_d  = 1'b0;

        // Compare for the read issued last cycle; first mismatch captures its address.
        if (mismatch) begin
            if (err_cnt_q == '0) begin
                fail_addr_d = pend_addr_q;
            end
            if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                if (addr_last) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                pend_vld_d = 1'b1;
                addr_d     = addr_q + 1'b1;
                if (addr_last) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end
            end
            S_DRAIN: begin
`ifdef BIST_INVERT_PASS_EN
                state_d = S_WRITE_INV;
`else
                state_d = S_DONE;
`endif
                addr_d  = '0;
            end
`ifdef BIST_INVERT_PASS_EN
            S_WRITE_INV: begin
                addr_d = addr_q + 1'b1;
                if (addr_last) begin
                    state_d = S_READ_INV;
                    addr_d  = '0;
                end
            end
            S_READ_INV: begin
                pend_vld_d = 1'b1;
                pend_inv_d = 1'b1;
                addr_d     = addr_q + 1'b1;
                if (addr_last) begin
                    state_d = S_DRAIN_INV;
                    addr_d  = '0;
                end
            end
            S_DRAIN_INV: begin
                state_d = S_DONE;
                addr_d  = '0;
            end
`endif
            S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_inv_q  <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_inv_q  <= pend_inv_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    assign ram_cs    = wr_phase | rd_phase;
    assign ram_wr    = wr_phase;
    assign ram_rd    = rd_phase;
    assign ram_addr  = (wr_phase | rd_phase) ? addr_q : '0;
    assign ram_wdata = wr_phase ? pattern(addr_q, wr_inv) : '0;

    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_cnt_q == '0);
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: behavioural faulty-RAM model, vector table, result scoreboard,
// protocol monitor and hand-written reset/restart sequences. Honours BIST_INVERT_PASS_EN.
module tb_ram_bist;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int N  = 1024;
`ifdef BIST_INVERT_PASS_EN
    localparam bit INV = 1'b1;
    localparam int LAT = 4 * N + 2;
`else
    localparam bit INV = 1'b0;
    localparam int LAT = 2 * N + 1;
`endif
    localparam int PASSES = INV ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] fail_addr;
    logic          ram_cs, ram_wr, ram_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .ram_cs(ram_cs), .ram_wr(ram_wr),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: stores what is written, faults applied on the read path.
    logic [DW-1:0] mem   [N];
    logic [DW-1:0] and_m [N];
    logic [DW-1:0] or_m  [N];
    bit            all0 = 1'b0;

    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_rd) ram_rdata <= all0 ? 8'h00 : ((mem[ram_addr] & and_m[ram_addr]) | or_m[ram_addr]);
    end

    function automatic logic [7:0] pat(input int k, input bit inv);
        logic [7:0] p;
        p = 8'((2 * k) % 256);
        return inv ? ~p : p;
    endfunction

    // Protocol monitor: per-run write/read counts, in-order addresses and data, strobe rules.
    int       viol = 0;
    int       run_wr = 0;
    int       run_rd = 0;
    int       nxt_w = 0;
    bit       mon_busy_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !mon_busy_prev) begin
                run_wr = 0;
                run_rd = 0;
                nxt_w  = 0;
            end
            if (ram_wr && ram_rd) viol++;
            if (ram_cs != (ram_wr | ram_rd)) viol++;
            if (!busy && ram_cs) viol++;
            if (ram_wr) begin
                if (int'(ram_addr) != nxt_w || ram_wdata !== pat(nxt_w, run_wr >= N)) viol++;
                nxt_w = (nxt_w + 1) % N;
                run_wr++;
            end
            if (ram_rd) run_rd++;
            mon_busy_prev = busy;
        end else begin
            mon_busy_prev = 1'b0;
        end
    end

    typedef struct {
        int         fa0;
        logic [7:0] and0;
        logic [7:0] or0;
        int         fa1;
        logic [7:0] and1;
        logic [7:0] or1;
        bit         all_zero;
        bit         exp_pass;
        int         exp_err;
        int         exp_fail;
    } vec_t;

    typedef struct {
        bit pass;
        int err;
        int fail;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_faults(input vec_t v);
        for (int i = 0; i < N; i++) begin
            and_m[i] = 8'hFF;
            or_m[i]  = 8'h00;
        end
        if (v.fa0 >= 0) begin
            and_m[v.fa0] = v.and0;
            or_m[v.fa0]  = v.or0;
        end
        if (v.fa1 >= 0) begin
            and_m[v.fa1] = v.and1;
            or_m[v.fa1]  = v.or1;
        end
        all0 = v.all_zero;
    endtask

    task automatic do_start(input exp_t e, input bit push, output int c0);
        @(negedge clk);
        start = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        @(negedge clk);
        check("start_clear", {busy, done, err_cnt, fail_addr}, {1'b1, 1'b0, 12'd0, 10'd0});
    endtask

    task automatic wait_done(input int c0, input int viol0);
        bit   prev_busy;
        bit   seen;
        exp_t e;
        prev_busy = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < LAT + 200; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            prev_busy = busy;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done not seen within %0d cycles", LAT + 200);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: done seen with no expected result queued");
            return;
        end
        e = sb.pop_front();
        check("done_latency", cyc - c0, e.lat);
        check("busy_drop", {prev_busy, busy}, 2'b10);
        check("pass", pass, e.pass);
        check("err_cnt", err_cnt, e.err);
        check("fail_addr", fail_addr, e.fail);
        check("write_cycles", run_wr, PASSES * N);
        check("read_cycles", run_rd, PASSES * N);
        check("protocol_violations", viol - viol0, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int   c0;
        int   v0;
        exp_t e;

        vecs[0] = '{-1, 8'hFF, 8'h00, -1, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0};
        vecs[1] = '{300, 8'h00, 8'h00, 700, 8'hFF, 8'hFF, 1'b0, 1'b0, INV ? 4 : 2, 300};
        vecs[2] = '{10, 8'hFE, 8'h00, -1, 8'hFF, 8'h00, 1'b0, !INV, INV ? 1 : 0, INV ? 10 : 0};
        vecs[3] = '{1023, 8'h00, 8'h00, -1, 8'hFF, 8'h00, 1'b0, 1'b0, INV ? 2 : 1, 1023};
        vecs[4] = '{0, 8'hFF, 8'h01, -1, 8'hFF, 8'h00, 1'b0, 1'b0, 1, 0};
        vecs[5] = '{-1, 8'hFF, 8'h00, -1, 8'hFF, 8'h00, 1'b1, 1'b0, INV ? 2040 : 1016, 1};

        rst_n = 1'b0;
        start = 1'b0;
        apply_faults(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, pass, err_cnt, fail_addr, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply_faults(vecs[i]);
            e.pass = vecs[i].exp_pass;
            e.err  = vecs[i].exp_err;
            e.fail = vecs[i].exp_fail;
            e.lat  = LAT;
            v0 = viol;
            do_start(e, 1'b1, c0);
            wait_done(c0, v0);
            if (i == 0) begin
                check("mem_5", mem[5], INV ? 8'hF5 : 8'h0A);
                check("mem_200", mem[200], INV ? 8'h6F : 8'h90);
            end
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of a run: outputs drop at once and the run is not resumed.
        apply_faults(vecs[0]);
        do_start(e, 1'b0, c0);
        while (cyc < c0 + 1500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy, done, pass, err_cnt, fail_addr, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_resume", {busy, done, ram_cs}, 3'b000);

        // Restart after reset, with a start pulse while busy that must be ignored.
        e.pass = 1'b1;
        e.err  = 0;
        e.fail = 0;
        e.lat  = LAT;
        v0 = viol;
        do_start(e, 1'b1, c0);
        while (cyc < c0 + 99) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c0, v0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
